// File: rtl/adc_frame_packer.sv
// adc_frame_packer
// Packs 16-bit ADC samples {data_a, data_b} into framed 32-bit words for the
// fiber TX write FIFO: header {SYNC_TAG, seq}, N/2 payload words {even, odd},
// and, when FRAME_CSUM_EN is defined, a trailer {TRAIL_TAG, sum16}.
// A frame whose first sample arrives while the FIFO is almost full is
// swallowed whole, so the receiver only ever sees complete frames.
// Optional feature macro: FRAME_CSUM_EN (checksum trailer and TRAIL state).
module adc_frame_packer #(
   parameter int unsigned SAMPLES_PER_FRAME = 256,
   parameter logic [15:0] SYNC_TAG          = 16'hEB90
`ifdef FRAME_CSUM_EN
   ,parameter logic [15:0] TRAIL_TAG        = 16'hC3C3
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        smp_valid,
   input  logic [15:0] smp_data,
   input  logic        fifo_almost_full,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [15:0] frame_seq,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt,
   output logic        busy
);

   // Sample index counter is wide enough for 0..N-1.
   localparam int CNT_W = $clog2(SAMPLES_PER_FRAME);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_FRAME - 1);

`ifdef FRAME_CSUM_EN
   typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP, ST_TRAIL} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP} state_t;
`endif

   // Saturating 16-bit increment for the drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [31:0]      r_out_data;
   logic [15:0]      r_frame_seq;
   logic [15:0]      r_frame_cnt;
   logic [15:0]      r_drop_cnt;
   logic [15:0]      r_even;
`ifdef FRAME_CSUM_EN
   logic [15:0]      r_csum;
`endif

   logic w_start;
   logic w_pay_acc;
   logic w_last;

   // Frame start is only recognised in IDLE; enable is ignored once a frame runs.
   assign w_start   = (r_state == ST_IDLE) && smp_valid && enable;
   assign w_pay_acc = (r_state == ST_PAYLOAD) && smp_valid;
   assign w_last    = (r_cnt == LAST_IDX);

   // Framing FSM with registered output word, sequence and frame/drop counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
         r_frame_seq <= 16'd0;
         r_frame_cnt <= 16'd0;
         r_drop_cnt  <= 16'd0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  // Start sample is index 0; the next one accepted is index 1.
                  r_frame_seq <= r_frame_seq + 16'd1;
                  r_cnt       <= CNT_W'(1);
                  if (fifo_almost_full) begin
                     r_state    <= ST_DROP;
                     r_drop_cnt <= sat_inc16(r_drop_cnt);
                  end else begin
                     r_state     <= ST_PAYLOAD;
                     r_out_valid <= 1'b1;
                     r_out_data  <= {SYNC_TAG, r_frame_seq};
                  end
               end
            end
            ST_PAYLOAD: begin
               if (smp_valid) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  // Odd index completes the word started by the held even sample.
                  if (r_cnt[0]) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= {r_even, smp_data};
                  end
                  if (w_last) begin
`ifdef FRAME_CSUM_EN
                     r_state <= ST_TRAIL;
`else
                     r_state     <= ST_IDLE;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
                  end
               end
            end
            ST_DROP: begin
               if (smp_valid) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
`ifdef FRAME_CSUM_EN
            ST_TRAIL: begin
               // Any sample offered here is discarded; the sum is already final.
               r_out_valid <= 1'b1;
               r_out_data  <= {TRAIL_TAG, r_csum};
               r_frame_cnt <= r_frame_cnt + 16'd1;
               r_state     <= ST_IDLE;
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Sample holding register and running checksum; pure datapath, no reset needed.
   always_ff @(posedge clk) begin
      if (w_start || (w_pay_acc && !r_cnt[0])) begin
         r_even <= smp_data;
      end
`ifdef FRAME_CSUM_EN
      if (w_start) begin
         r_csum <= smp_data;
      end else if (w_pay_acc) begin
         r_csum <= r_csum + smp_data;
      end
`endif
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign frame_seq = r_frame_seq;
   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Packs the 16-bit dual-edge ADC sample stream (`{data_a, data_b}`, both captured in the ADC clock domain) into framed 32-bit words. Each frame is a header word, then payload words, then an optional checksum trailer. Sits between the ADC capture registers and the fiber TX write FIFO (`wfifo3_wr_en` / `wfifo3_wr_data`). It drops whole frames when the FIFO reports almost-full at frame start, so the receiver never sees a partial frame.

## Interface
- `SAMPLES_PER_FRAME`, 256, 16-bit samples per frame; even, 2..4096
- `SYNC_TAG`, 16'hEB90, upper half of header word
- `TRAIL_TAG`, 16'hC3C3, upper half of trailer word (only with `FRAME_CSUM_EN`)
- `clk` in 1: ADC sample clock (`Adc_Clk_A`)
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: capture enable; level; sampled only in IDLE
- `smp_valid` in 1: sample strobe
- `smp_data` in 16: sample `{data_a, data_b}`
- `fifo_almost_full` in 1: from the fiber write FIFO
- `out_valid` in→out 1: FIFO write enable
- `out_data` out 32: FIFO write data
- `frame_seq` out 16: sequence number of the next frame to start
- `frame_cnt` out 16: frames fully emitted; wraps
- `drop_cnt` out 16: frames dropped; saturates at 16'hFFFF
- `busy` out 1: state is not IDLE

## Operation
- **States:** IDLE, PAYLOAD, DROP, TRAIL (TRAIL exists only with `FRAME_CSUM_EN`).
- **IDLE, frame start:**
  - Start condition is `smp_valid && enable`.
  - That sample is sample 0 of the frame.
  - If `fifo_almost_full` is 0: go to PAYLOAD and emit the header `{SYNC_TAG, frame_seq}`.
  - If `fifo_almost_full` is 1: go to DROP, emit nothing, and increment `drop_cnt` (saturating).
  - `frame_seq` increments (wraps) on every frame start, emitted or dropped, so dropped frames appear as sequence gaps.
- **IDLE, no start:** `smp_valid` with `enable` = 0 is ignored.
- **PAYLOAD:**
  - Samples are counted 0..N-1.
  - Even-index sample is held in `[31:16]`.
  - The following odd-index sample completes the word `{even, odd}`, which is emitted.
  - `fifo_almost_full` is ignored mid-frame. The FIFO threshold must leave room for one full frame.
- **End of frame (sample N-1 accepted):**
  - With `FRAME_CSUM_EN`: go to TRAIL.
  - Without it: go to IDLE and increment `frame_cnt`.
- **TRAIL:**
  - Lasts one cycle.
  - Emits `{TRAIL_TAG, csum}`, increments `frame_cnt`, then returns to IDLE.
  - A sample presented in this cycle is discarded and not counted.
- **DROP:** consumes N valid samples without output, then returns to IDLE.
- **`enable` falling mid-frame:** the current frame completes normally.
- **`smp_valid` gaps:** allowed anywhere; the counters hold.
- **Reset (async, any state):**
  - State goes to IDLE.
  - `out_valid` = 0 and `out_data` = 0 immediately.
  - `frame_seq`, `frame_cnt`, `drop_cnt` = 0; `busy` = 0.
  - A partial frame is abandoned with no trailer.

## Timing
- All outputs are registered.
- **Header:** `out_valid` rises in the cycle after sample 0 is accepted (t+1).
- **Payload word k:** emitted the cycle after sample 2k+1 is accepted. The earliest is t+2, so it never collides with the header.
- **Trailer:** emitted the cycle after the last payload word (t_last+2).
- **Next frame start:**
  - With `FRAME_CSUM_EN`: earliest start is t_last+2 (one sample gap per frame).
  - Without it: earliest start is t_last+1, so frames run back-to-back.
- **Counter update timing:** `frame_cnt` updates in the same cycle the final word of the frame is driven. `drop_cnt` and `frame_seq` update the cycle after the start sample.
- **`busy`:** high from t+1 until the cycle after the return to IDLE.
- **Steady-state rate:** at most one `out_valid` per cycle, at least one idle cycle between payload words at full sample rate.

## Configuration
- **`FRAME_CSUM_EN` defined:**
  - TRAIL state and trailer word are present.
  - `csum` is the modulo-2^16 sum of all N payload samples of the frame.
  - `csum` is cleared at frame start.
- **`FRAME_CSUM_EN` undefined:** no TRAIL state, no trailer, no checksum adder, and back-to-back frames are allowed.

## Test plan
- **Single frame:** N=4, `enable`=1, AF=0, continuous samples 16'h0001..16'h0004.
  - Expect `out_data` = 32'hEB90_0000, then 32'h0001_0002, then 32'h0003_0004, then (with macro) 32'hC3C3_000A.
  - Expect `frame_cnt` = 1 and `frame_seq` = 1.
- **Dropped frame:** `fifo_almost_full`=1 at sample 0 of frame 2, then deasserted.
  - Expect no output for 4 samples and `drop_cnt` = 1.
  - The next emitted header is 32'hEB90_0002.
- **Gapped input:** `smp_valid` toggles every other cycle, N=4.
  - Expect the same four words as the single-frame case.
  - Each payload word appears exactly one cycle after its odd sample.
- **Back-to-back streaming:** continuous samples for 3 frames.
  - With macro: one discarded sample between frames; headers show seq 0, 1, 2.
  - Without macro: zero gaps and 9 words total.
- **Reset mid-frame:** assert `rst_n`=0 after sample 1.
  - Expect `out_valid` = 0 at once and all counters 0.
  - After release, the next header is 32'hEB90_0000.
- **`enable` handling:** deassert `enable` after sample 1.
  - The frame still completes.
  - No further headers until `enable` returns to 1.
